// File: rtl/mem_access_unit32_pkg.sv
// mem_access_unit32_pkg
// Shared definitions for the load/store unit:
//   - funct3 access codes (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//   - response cause codes (cause_t)
//   - FSM state encoding (state_t)
//   - access_size(): byte count touched by a given access code
package mem_access_unit32_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        CAUSE_OK       = 2'b00,
        CAUSE_ILLEGAL  = 2'b01,
        CAUSE_MISALIGN = 2'b10,
        CAUSE_RANGE    = 2'b11
    } cause_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    // Illegal codes report size 1; their cause is decided before range matters.
    function automatic logic [2:0] access_size(input logic [2:0] funct3);
        logic [2:0] size;
        size = 3'd1;
        case (funct3)
            F3_H, F3_HU: size = 3'd2;
            F3_W:        size = 3'd4;
            default:     size = 3'd1;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/mem_access_unit32_if.sv
// mem_access_unit32_if
// Bundles the three buses of the load/store unit:
//   - request  (execute -> unit): req_valid/req_ready plus request fields
//   - response (unit -> writeback): resp_valid/resp_ready plus data, rd, cause
//   - memory   (unit <-> data memory): write strobe, address, write data,
//     access code, combinational read data
// Modports:
//   master - the environment (execute, writeback and data memory)
//   slave  - the load/store unit itself
interface mem_access_unit32_if #(parameter int n = 32);

    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [n-1:0]  req_base;
    logic [11:0]   req_offset;
    logic [2:0]    req_funct3;
    logic [n-1:0]  req_store_data;
    logic [4:0]    req_rd;

    logic          resp_valid;
    logic          resp_ready;
    logic [n-1:0]  resp_data;
    logic [4:0]    resp_rd;
    logic [1:0]    resp_cause;

    logic          mem_write_enable;
    logic [n-1:0]  mem_addr;
    logic [n-1:0]  mem_write_data;
    logic [2:0]    mem_data_control;
    logic [n-1:0]  mem_read_data;

    modport master (
        output req_valid, req_write, req_base, req_offset, req_funct3,
               req_store_data, req_rd, resp_ready, mem_read_data,
        input  req_ready, resp_valid, resp_data, resp_rd, resp_cause,
               mem_write_enable, mem_addr, mem_write_data, mem_data_control
    );

    modport slave (
        input  req_valid, req_write, req_base, req_offset, req_funct3,
               req_store_data, req_rd, resp_ready, mem_read_data,
        output req_ready, resp_valid, resp_data, resp_rd, resp_cause,
               mem_write_enable, mem_addr, mem_write_data, mem_data_control
    );

endinterface

// File: rtl/mem_access_unit32_lsu_addr_check.sv
// lsu_addr_check
// Purely combinational effective-address and legality check.
//   base, offset(12b signed), funct3, write -> eff, cause
// Cause priority: illegal code, then misalignment, then out of range.
// Kept free of load/store-unit state so an instruction-fetch check can reuse it.
module lsu_addr_check
    import mem_access_unit32_pkg::*;
#(
    parameter int n          = 32,
    parameter int ADDR_LIMIT = 1024
) (
    input  logic [n-1:0] base,
    input  logic [11:0]  offset,
    input  logic [2:0]   funct3,
    input  logic         write,
    output logic [n-1:0] eff,
    output cause_t       cause
);

    logic         legal;
    logic         misaligned;
    logic [n:0]   last_byte;

    assign eff = base + {{(n-12){offset[11]}}, offset};

    // The last touched byte is formed one bit wider than the address so an
    // access that wraps past 2^n still lands above the limit.
    always_comb begin
        legal      = 1'b0;
        misaligned = 1'b0;
        cause      = CAUSE_OK;

        if (write)
            legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        else
            legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                    (funct3 == F3_BU) || (funct3 == F3_HU);

        misaligned = (((funct3 == F3_H) || (funct3 == F3_HU)) && eff[0]) ||
                     ((funct3 == F3_W) && (eff[1:0] != 2'b00));

        last_byte = {1'b0, eff} + (n+1)'(access_size(funct3)) - (n+1)'(1);

        if (!legal)
            cause = CAUSE_ILLEGAL;
        else if (misaligned)
            cause = CAUSE_MISALIGN;
        else if (last_byte >= (n+1)'(ADDR_LIMIT))
            cause = CAUSE_RANGE;
    end

endmodule

// File: rtl/mem_access_unit32.sv
// mem_access_unit32
// Load/store unit between execute and the data memory.
//   clk, rst - clock and synchronous active-high reset
//   bus      - request, response and data-memory buses (slave modport)
// A legal request spends one ACCESS cycle on the memory bus, then waits in
// RESP until writeback takes the result. Errors skip ACCESS entirely.
module mem_access_unit32
    import mem_access_unit32_pkg::*;
#(
    parameter int n          = 32,
    parameter int ADDR_LIMIT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_access_unit32_if.slave   bus
);

    state_t        state;
    state_t        next_state;

    logic [n-1:0]  chk_eff;
    cause_t        chk_cause;

    logic          write_q;
    logic [4:0]    rd_q;
    logic [n-1:0]  resp_data_q;
    cause_t        cause_q;
    logic [n-1:0]  addr_q;
    logic [n-1:0]  wdata_q;
    logic [2:0]    ctrl_q;

    lsu_addr_check #(
        .n          (n),
        .ADDR_LIMIT (ADDR_LIMIT)
    ) u_addr_check (
        .base   (bus.req_base),
        .offset (bus.req_offset),
        .funct3 (bus.req_funct3),
        .write  (bus.req_write),
        .eff    (chk_eff),
        .cause  (chk_cause)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Handshake and strobe outputs are gated by rst so a reset landing in
    // ACCESS never commits a write and one landing in RESP drops the response.
    always_comb begin
        next_state           = state;
        bus.req_ready        = 1'b0;
        bus.resp_valid       = 1'b0;
        bus.mem_write_enable = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = !rst;
                if (bus.req_valid)
                    next_state = (chk_cause == CAUSE_OK) ? ACCESS : RESP;
            end
            ACCESS: begin
                bus.mem_write_enable = write_q && !rst;
                next_state           = RESP;
            end
            RESP: begin
                bus.resp_valid = !rst;
                if (bus.resp_ready)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Request fields are captured on acceptance; resp_data starts at zero so
    // stores and errors report 0, and loads overwrite it at the end of ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_q     <= 1'b0;
            rd_q        <= '0;
            resp_data_q <= '0;
            cause_q     <= CAUSE_OK;
            addr_q      <= '0;
            wdata_q     <= '0;
            ctrl_q      <= '0;
        end else begin
            if (state == IDLE && bus.req_valid) begin
                write_q     <= bus.req_write;
                rd_q        <= bus.req_rd;
                resp_data_q <= '0;
                cause_q     <= chk_cause;
                addr_q      <= chk_eff;
                wdata_q     <= bus.req_store_data;
                ctrl_q      <= bus.req_funct3;
            end else if (state == ACCESS && !write_q) begin
                resp_data_q <= bus.mem_read_data;
            end
        end
    end

    assign bus.resp_data        = resp_data_q;
    assign bus.resp_rd          = rd_q;
    assign bus.resp_cause       = cause_q;
    assign bus.mem_addr         = addr_q;
    assign bus.mem_write_data   = wdata_q;
    assign bus.mem_data_control = ctrl_q;

endmodule

// File: tb/tb_mem_access_unit32.sv
// tb_mem_access_unit32
// Scoreboard bench for mem_access_unit32 with a big-endian byte memory model.
// Expected responses and expected memory writes are queued when a request is
// issued; two monitors pop and compare when the DUT presents them.
module tb_mem_access_unit32;
    import mem_access_unit32_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic [1:0]  cause;
    } resp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  ctrl;
        logic [31:0] data;
    } wr_t;

    logic clk;
    logic rst;

    mem_access_unit32_if #(.n(32)) bus();

    mem_access_unit32 #(.n(32), .ADDR_LIMIT(1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int     checks   = 0;
    int     failures = 0;
    resp_t  exp_resp[$];
    wr_t    exp_wr[$];

    logic [7:0]  mem [0:1023];
    bit          mem_ready = 1'b0;
    logic [9:0]  rd_a;
    logic [31:0] rd_val;

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: cleared on the first edge, then written on strobed edges
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
            mem_ready <= 1'b1;
        end else if (bus.mem_write_enable) begin
            case (bus.mem_data_control)
                F3_B: mem[bus.mem_addr[9:0]] <= bus.mem_write_data[7:0];
                F3_H: begin
                    mem[bus.mem_addr[9:0]]         <= bus.mem_write_data[15:8];
                    mem[bus.mem_addr[9:0] + 10'd1] <= bus.mem_write_data[7:0];
                end
                default: begin
                    mem[bus.mem_addr[9:0]]         <= bus.mem_write_data[31:24];
                    mem[bus.mem_addr[9:0] + 10'd1] <= bus.mem_write_data[23:16];
                    mem[bus.mem_addr[9:0] + 10'd2] <= bus.mem_write_data[15:8];
                    mem[bus.mem_addr[9:0] + 10'd3] <= bus.mem_write_data[7:0];
                end
            endcase
        end
    end

    // Combinational, extended read data
    always_comb begin
        rd_a   = bus.mem_addr[9:0];
        rd_val = '0;
        case (bus.mem_data_control)
            F3_B:  rd_val = {{24{mem[rd_a][7]}}, mem[rd_a]};
            F3_BU: rd_val = {24'h0, mem[rd_a]};
            F3_H:  rd_val = {{16{mem[rd_a][7]}}, mem[rd_a], mem[rd_a + 10'd1]};
            F3_HU: rd_val = {16'h0, mem[rd_a], mem[rd_a + 10'd1]};
            default: rd_val = {mem[rd_a], mem[rd_a + 10'd1], mem[rd_a + 10'd2], mem[rd_a + 10'd3]};
        endcase
    end
    assign bus.mem_read_data = rd_val;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    // Response monitor: compares whenever a response is handed over
    always @(negedge clk) begin
        if (bus.resp_valid && bus.resp_ready) begin
            if (exp_resp.size() == 0) begin
                checkOutput("unexpected_resp", 32'd1, 32'd0);
            end else begin
                resp_t e;
                e = exp_resp.pop_front();
                checkOutput("resp_data",  bus.resp_data,          e.data);
                checkOutput("resp_rd",    {27'h0, bus.resp_rd},   {27'h0, e.rd});
                checkOutput("resp_cause", {30'h0, bus.resp_cause}, {30'h0, e.cause});
            end
        end
    end

    // Memory write monitor: any strobe must match a queued store
    always @(negedge clk) begin
        if (bus.mem_write_enable) begin
            if (exp_wr.size() == 0) begin
                checkOutput("unexpected_write", bus.mem_addr, 32'hFFFF_FFFF);
            end else begin
                wr_t w;
                w = exp_wr.pop_front();
                checkOutput("mem_addr",         bus.mem_addr,                  w.addr);
                checkOutput("mem_data_control", {29'h0, bus.mem_data_control}, {29'h0, w.ctrl});
                checkOutput("mem_write_data",   bus.mem_write_data,            w.data);
            end
        end
    end

    task automatic waitReady();
        int waited;
        waited = 0;
        @(negedge clk);
        while (!bus.req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("req_ready_wait", {31'h0, bus.req_ready}, 32'd1);
    endtask

    task automatic driveReq(input bit wr, input logic [31:0] base, input logic [11:0] off,
                            input logic [2:0] f3, input logic [31:0] sdata, input logic [4:0] rd);
        bus.req_valid      = 1'b1;
        bus.req_write      = wr;
        bus.req_base       = base;
        bus.req_offset     = off;
        bus.req_funct3     = f3;
        bus.req_store_data = sdata;
        bus.req_rd         = rd;
    endtask

    // Issue one request, queue its expectations and check response latency
    task automatic applyStimulus(input bit wr, input logic [31:0] base, input logic [11:0] off,
                                 input logic [2:0] f3, input logic [31:0] sdata, input logic [4:0] rd,
                                 input logic [31:0] exp_data, input logic [1:0] exp_cause,
                                 input logic [31:0] exp_addr);
        int lat;
        waitReady();
        driveReq(wr, base, off, f3, sdata, rd);
        exp_resp.push_back('{data: exp_data, rd: rd, cause: exp_cause});
        if (wr && exp_cause == CAUSE_OK)
            exp_wr.push_back('{addr: exp_addr, ctrl: f3, data: sdata});
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.resp_valid && lat < 10);
        checkOutput("resp_latency", lat, (exp_cause == CAUSE_OK) ? 32'd2 : 32'd1);
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_base = '0;
        bus.req_offset = '0;
        bus.req_funct3 = '0;
        bus.req_store_data = '0;
        bus.req_rd = '0;
        bus.resp_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req_ready",  {31'h0, bus.req_ready},        32'd0);
        checkOutput("rst_resp_valid", {31'h0, bus.resp_valid},       32'd0);
        checkOutput("rst_mem_we",     {31'h0, bus.mem_write_enable}, 32'd0);
        checkOutput("rst_mem_addr",   bus.mem_addr,                  32'd0);
        checkOutput("rst_mem_wdata",  bus.mem_write_data,            32'd0);
        checkOutput("rst_mem_ctrl",   {29'h0, bus.mem_data_control}, 32'd0);
        checkOutput("rst_resp_data",  bus.resp_data,                 32'd0);
        checkOutput("rst_resp_rd",    {27'h0, bus.resp_rd},          32'd0);
        checkOutput("rst_resp_cause", {30'h0, bus.resp_cause},       32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_req_ready", {31'h0, bus.req_ready}, 32'd1);

        // Store then loads (memory is big-endian)
        applyStimulus(1, 32'h100, 12'd4, F3_W,  32'hDEADBEEF, 5'd0, 32'h0,        CAUSE_OK, 32'h104);
        applyStimulus(0, 32'h100, 12'd4, F3_W,  32'h0,        5'd5, 32'hDEADBEEF, CAUSE_OK, 32'h0);
        applyStimulus(0, 32'h104, 12'd0, F3_B,  32'h0,        5'd6, 32'hFFFFFFDE, CAUSE_OK, 32'h0);
        applyStimulus(0, 32'h104, 12'd0, F3_BU, 32'h0,        5'd7, 32'h000000DE, CAUSE_OK, 32'h0);
        applyStimulus(0, 32'h100, 12'd6, F3_H,  32'h0,        5'd8, 32'hFFFFBEEF, CAUSE_OK, 32'h0);
        applyStimulus(0, 32'h100, 12'd6, F3_HU, 32'h0,        5'd9, 32'h0000BEEF, CAUSE_OK, 32'h0);

        // Misaligned and illegal
        applyStimulus(0, 32'h102, 12'd0, F3_W,   32'h0,        5'd10, 32'h0, CAUSE_MISALIGN, 32'h0);
        applyStimulus(1, 32'h101, 12'd0, F3_H,   32'h0000AAAA, 5'd11, 32'h0, CAUSE_MISALIGN, 32'h0);
        applyStimulus(0, 32'h100, 12'd0, F3_W,   32'h0,        5'd12, 32'h0, CAUSE_OK,       32'h0);
        applyStimulus(1, 32'h100, 12'd0, 3'b100, 32'h12345678, 5'd13, 32'h0, CAUSE_ILLEGAL,  32'h0);
        applyStimulus(0, 32'h100, 12'd0, 3'b011, 32'h0,        5'd14, 32'h0, CAUSE_ILLEGAL,  32'h0);

        // Range boundaries
        applyStimulus(0, 32'h3FC, 12'd0,     F3_W,  32'h0,        5'd15, 32'h0,        CAUSE_OK,       32'h0);
        applyStimulus(0, 32'h400, 12'd0,     F3_B,  32'h0,        5'd16, 32'h0,        CAUSE_RANGE,    32'h0);
        applyStimulus(0, 32'h010, 12'hFE0,   F3_W,  32'h0,        5'd17, 32'h0,        CAUSE_RANGE,    32'h0);
        applyStimulus(0, 32'h3FE, 12'd0,     F3_H,  32'h0,        5'd18, 32'h0,        CAUSE_OK,       32'h0);
        applyStimulus(0, 32'h3FF, 12'd0,     F3_H,  32'h0,        5'd19, 32'h0,        CAUSE_MISALIGN, 32'h0);
        applyStimulus(1, 32'h3FF, 12'd0,     F3_B,  32'h00000080, 5'd20, 32'h0,        CAUSE_OK,       32'h3FF);
        applyStimulus(0, 32'h3FF, 12'd0,     F3_B,  32'h0,        5'd0,  32'hFFFFFF80, CAUSE_OK,       32'h0);
        applyStimulus(0, 32'h3FF, 12'd0,     F3_BU, 32'h0,        5'd21, 32'h00000080, CAUSE_OK,       32'h0);

        // Backpressure: response held while new requests are offered
        waitReady();
        bus.resp_ready = 1'b0;
        driveReq(0, 32'h104, 12'd0, F3_W, 32'h0, 5'd7);
        exp_resp.push_back('{data: 32'hDEADBEEF, rd: 5'd7, cause: CAUSE_OK});
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_resp_valid", {31'h0, bus.resp_valid}, 32'd1);
            checkOutput("bp_resp_data",  bus.resp_data,           32'hDEADBEEF);
            checkOutput("bp_resp_rd",    {27'h0, bus.resp_rd},    32'd7);
            checkOutput("bp_req_ready",  {31'h0, bus.req_ready},  32'd0);
            if (i % 2 == 0)
                driveReq(1, 32'h300, 12'd0, F3_W, 32'h00000055, 5'd9);
            else
                bus.req_valid = 1'b0;
            @(negedge clk);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("bp_release_req_ready",  {31'h0, bus.req_ready},  32'd1);
        checkOutput("bp_release_resp_valid", {31'h0, bus.resp_valid}, 32'd0);
        applyStimulus(0, 32'h300, 12'd0, F3_W, 32'h0, 5'd22, 32'h0, CAUSE_OK, 32'h0);

        // Reset during ACCESS of a store
        waitReady();
        driveReq(1, 32'h200, 12'd0, F3_W, 32'h11223344, 5'd3);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_mem_we",     {31'h0, bus.mem_write_enable}, 32'd0);
        checkOutput("mid_rst_req_ready",  {31'h0, bus.req_ready},        32'd0);
        checkOutput("mid_rst_resp_valid", {31'h0, bus.resp_valid},       32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("after_rst_req_ready",  {31'h0, bus.req_ready},  32'd1);
        checkOutput("after_rst_resp_valid", {31'h0, bus.resp_valid}, 32'd0);
        checkOutput("after_rst_mem_addr",   bus.mem_addr,            32'd0);
        applyStimulus(0, 32'h200, 12'd0, F3_W, 32'h0, 5'd4, 32'h0, CAUSE_OK, 32'h0);

        repeat (3) @(negedge clk);
        checkOutput("resp_queue_empty",  exp_resp.size(), 32'd0);
        checkOutput("write_queue_empty", exp_wr.size(),   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
